// File: rtl/wb_ram_slave.sv
// Classic Wishbone word-addressed RAM slave; ack/err arrive WAIT+1 edges after accept.
// Out-of-range addresses terminate with errO, and a dropped strobe aborts the transfer.
module wb_ram_slave #(
    parameter int DEPTH     = 256,
    parameter int WAIT      = 1,
    parameter int INIT_ZERO = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cycI,
    input  logic        stbI,
    input  logic        weI,
    input  logic [31:0] adrI,
    input  logic [31:0] datI,
    output logic        ackO,
    output logic        errO,
    output logic [31:0] datO
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAITING,
        DONE
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] adrQ;
    logic [31:0] datQ;
    logic        weQ;

    logic [31:0] mem [DEPTH] = '{default: (INIT_ZERO != 0) ? 32'h0 : 32'hx};

    logic          req;
    logic          accessNow;
    logic [31:0]   accAdr;
    logic [31:0]   accDat;
    logic          accWe;
    logic          inRange;
    logic [AW-1:0] idx;
    logic          memWe;

    assign req = cycI & stbI;

    // With no wait states the access happens on the accept edge itself,
    // so the live bus inputs stand in for the not-yet-latched copies.
    always_comb begin
        accessNow = 1'b0;
        accAdr    = adrQ;
        accDat    = datQ;
        accWe     = weQ;
        if (state == IDLE) begin
            accAdr    = adrI;
            accDat    = datI;
            accWe     = weI;
            accessNow = req && (WAIT == 0);
        end else if (state == WAITING) begin
            accessNow = req && (cnt == 4'd0);
        end
    end

    assign inRange = (accAdr < DEPTH);
    assign idx     = accAdr[AW-1:0];
    assign memWe   = accessNow & accWe & inRange & ~rst;

    always_ff @(posedge clk) begin
        if (memWe) begin
            mem[idx] <= accDat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            adrQ  <= 32'd0;
            datQ  <= 32'd0;
            weQ   <= 1'b0;
            ackO  <= 1'b0;
            errO  <= 1'b0;
            datO  <= 32'd0;
        end else begin
            ackO <= 1'b0;
            errO <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        adrQ <= adrI;
                        datQ <= datI;
                        weQ  <= weI;
                        if (WAIT == 0) begin
                            state <= DONE;
                        end else begin
                            cnt   <= 4'(WAIT - 1);
                            state <= WAITING;
                        end
                    end
                end
                WAITING: begin
                    if (!req) begin
                        state <= IDLE;
                    end else if (cnt == 4'd0) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (accessNow) begin
                if (inRange) begin
                    ackO <= 1'b1;
                    if (!accWe) begin
                        datO <= mem[idx];
                    end
                end else begin
                    errO <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_ram_slave.sv
module tb_wb_ram_slave;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // A: WAIT=1 instance, B: WAIT=3 instance
    logic        cycA = 0, stbA = 0, weA = 0;
    logic [31:0] adrA = '0, datA = '0;
    logic        ackA, errA;
    logic [31:0] doA;
    logic        cycB = 0, stbB = 0, weB = 0;
    logic [31:0] adrB = '0, datB = '0;
    logic        ackB, errB;
    logic [31:0] doB;

    int checks = 0;
    int errors = 0;

    wb_ram_slave #(.DEPTH(256), .WAIT(1), .INIT_ZERO(1)) dutA (
        .clk(clk), .rst(rst), .cycI(cycA), .stbI(stbA), .weI(weA),
        .adrI(adrA), .datI(datA), .ackO(ackA), .errO(errA), .datO(doA)
    );

    wb_ram_slave #(.DEPTH(256), .WAIT(3), .INIT_ZERO(1)) dutB (
        .clk(clk), .rst(rst), .cycI(cycB), .stbI(stbB), .weI(weB),
        .adrI(adrB), .datI(datB), .ackO(ackB), .errO(errB), .datO(doB)
    );

    task automatic drive(input bit b, input logic c, input logic s, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        if (b) begin
            cycB = c; stbB = s; weB = w; adrB = a; datB = d;
        end else begin
            cycA = c; stbA = s; weA = w; adrA = a; datA = d;
        end
    endtask

    // n = edges from accept (inclusive) to ack/err visible, 0 on timeout
    task automatic xfer(input bit b, input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int n, output logic gotAck, output logic gotErr,
                        output logic [31:0] rd, output logic post);
        n = 0; gotAck = 0; gotErr = 0; rd = '0; post = 0;
        @(negedge clk);
        drive(b, 1'b1, 1'b1, w, a, d);
        @(posedge clk);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            gotAck = b ? ackB : ackA;
            gotErr = b ? errB : errA;
            rd     = b ? doB : doA;
            if (gotAck || gotErr) begin
                n = i;
                break;
            end
        end
        drive(b, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        post = b ? (ackB | errB) : (ackA | errA);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({ackA, errA, doA, ackB, errB, doB} !== 68'd0) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: ackA=%b errA=%b doA=%h ackB=%b errB=%b doB=%h, want all 0",
                         i, ackA, errA, doA, ackB, errB, doB);
            end
        end
    endtask

    task automatic test_write_read();
        int n; logic ak, er, post; logic [31:0] rd;
        xfer(1'b0, 1'b1, 32'd5, 32'hDEADBEEF, n, ak, er, rd, post);
        checks++;
        if (n !== 2 || ak !== 1'b1 || er !== 1'b0 || post !== 1'b0) begin
            errors++;
            $display("FAIL write5: edges=%0d ack=%b err=%b post=%b, want edges=2 ack=1 err=0 post=0", n, ak, er, post);
        end
        xfer(1'b0, 1'b0, 32'd5, 32'd0, n, ak, er, rd, post);
        checks++;
        if (n !== 2 || ak !== 1'b1 || er !== 1'b0 || post !== 1'b0) begin
            errors++;
            $display("FAIL read5_timing: edges=%0d ack=%b err=%b post=%b, want edges=2 ack=1 err=0 post=0", n, ak, er, post);
        end
        checks++;
        if (rd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL read5_data: got %h want deadbeef", rd);
        end
    endtask

    task automatic test_out_of_range();
        int n; logic ak, er, post; logic [31:0] rd;
        xfer(1'b0, 1'b0, 32'd256, 32'd0, n, ak, er, rd, post);
        checks++;
        if (n !== 2 || ak !== 1'b0 || er !== 1'b1 || post !== 1'b0) begin
            errors++;
            $display("FAIL read256_err: edges=%0d ack=%b err=%b post=%b, want edges=2 ack=0 err=1 post=0", n, ak, er, post);
        end
        checks++;
        if (rd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL read256_dato_hold: got %h want deadbeef", rd);
        end
        // upper address bits must not alias onto word 5
        xfer(1'b0, 1'b1, 32'h0001_0005, 32'h12345678, n, ak, er, rd, post);
        checks++;
        if (n !== 2 || ak !== 1'b0 || er !== 1'b1) begin
            errors++;
            $display("FAIL write_alias_err: edges=%0d ack=%b err=%b, want edges=2 ack=0 err=1", n, ak, er);
        end
        xfer(1'b0, 1'b0, 32'd5, 32'd0, n, ak, er, rd, post);
        checks++;
        if (ak !== 1'b1 || rd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL alias_read5: ack=%b data=%h, want ack=1 data=deadbeef", ak, rd);
        end
        xfer(1'b0, 1'b0, 32'd0, 32'd0, n, ak, er, rd, post);
        checks++;
        if (n !== 2 || ak !== 1'b1 || rd !== 32'd0) begin
            errors++;
            $display("FAIL read0: edges=%0d ack=%b data=%h, want edges=2 ack=1 data=0", n, ak, rd);
        end
    endtask

    task automatic test_abort();
        int n; int seen; logic ak, er, post; logic [31:0] rd;
        seen = 0;
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'd7, 32'h11);
        @(posedge clk);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ackB || errB) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL abort_no_term: %0d ack/err cycles, want 0", seen);
        end
        xfer(1'b1, 1'b0, 32'd7, 32'd0, n, ak, er, rd, post);
        checks++;
        if (n !== 4 || ak !== 1'b1 || rd !== 32'd0 || post !== 1'b0) begin
            errors++;
            $display("FAIL abort_read7: edges=%0d ack=%b data=%h post=%b, want edges=4 ack=1 data=0 post=0", n, ak, rd, post);
        end
    endtask

    task automatic test_back_to_back();
        int n; logic ak, er, post; logic [31:0] rd;
        int acks; int lastCyc; int badGap; int badData;
        logic [31:0] expData [3];
        expData[0] = 32'hA1; expData[1] = 32'hB2; expData[2] = 32'hC3;
        for (int k = 0; k < 3; k++) begin
            xfer(1'b0, 1'b1, 32'(k + 1), expData[k], n, ak, er, rd, post);
        end
        acks = 0; lastCyc = -1; badGap = 0; badData = 0;
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'd1, 32'd0);
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (ackA) begin
                if (acks < 3 && doA !== expData[acks]) badData++;
                if (lastCyc >= 0 && c - lastCyc != 3) badGap++;
                lastCyc = c;
                acks++;
                if (acks >= 3) drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
                else           drive(1'b0, 1'b1, 1'b1, 1'b0, 32'(acks + 1), 32'd0);
            end
        end
        checks++;
        if (acks !== 3) begin
            errors++;
            $display("FAIL b2b_count: %0d acks, want 3", acks);
        end
        checks++;
        if (badGap !== 0) begin
            errors++;
            $display("FAIL b2b_spacing: %0d gaps not equal to 3 cycles, want 0", badGap);
        end
        checks++;
        if (badData !== 0) begin
            errors++;
            $display("FAIL b2b_data: %0d wrong read values, want 0", badData);
        end
    endtask

    task automatic test_reset_mid();
        int n; int seen; logic ak, er, post; logic [31:0] rd;
        seen = 0;
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'd9, 32'h55);
        @(posedge clk);
        #3 rst = 1'b1;
        @(negedge clk);
        if (ackA || errA) seen++;
        checks++;
        if (doA !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid_dato: got %h want 0", doA);
        end
        @(posedge clk);
        @(negedge clk);
        if (ackA || errA) seen++;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ackA || errA) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL rst_mid_no_ack: %0d ack/err cycles, want 0", seen);
        end
        xfer(1'b0, 1'b0, 32'd9, 32'd0, n, ak, er, rd, post);
        checks++;
        if (n !== 2 || ak !== 1'b1 || rd !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid_read9: edges=%0d ack=%b data=%h, want edges=2 ack=1 data=0", n, ak, rd);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_out_of_range();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_ram_slave.md
Name: wb_ram_slave

Overview:
- Classic (non-pipelined) Wishbone slave: word-addressed on-chip RAM with a programmable number of wait states.
- Sits directly downstream of the two-master arbiter and is driven by its single slave-side port (cyc/stb/we/adr/dat out, ack/dat in).
- Addresses outside the RAM are answered with an error strobe instead of ack, so a stray master access can never hang the bus.

Parameters:
- DEPTH, 256, number of 32-bit words; valid word addresses are 0..DEPTH-1; any DEPTH >= 1 is legal.
- WAIT, 1, wait cycles inserted between accept and ack/err; range 0..15.
- INIT_ZERO, 1, if 1 the RAM simulation image is zero at time 0; otherwise contents start as X.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cycI  in  1  bus cycle active.
- stbI  in  1  transfer strobe.
- weI  in  1  1 = write, 0 = read.
- adrI  in  32  word address; not a byte address.
- datI  in  32  write data.
- ackO  out  1  normal termination, registered, one-cycle pulse.
- errO  out  1  error termination (out-of-range address), registered, one-cycle pulse.
- datO  out  32  read data; valid in the ackO cycle.

Behaviour:
- Reset (asynchronous, active-high):
  - Forces state=IDLE, ackO=0, errO=0, datO=0, wait counter=0.
  - RAM contents are not altered by reset.
  - Reset asserted mid-transfer aborts it with no write and no ack/err, including when reset lands in the would-be ack cycle.
- Request = cycI & stbI, sampled on the rising edge.
- FSM states: IDLE, WAITING, DONE.
- IDLE:
  - On a rising edge with request=1, latch adrI, datI and weI (the accept edge).
  - If WAIT=0, perform the access at this same edge and go to DONE.
  - Otherwise load counter=WAIT-1 and go to WAITING.
- WAITING:
  - If request=0 at an edge (master abort), go to IDLE: no write, no ack, no err.
  - Otherwise, if counter=0, perform the access and go to DONE.
  - Otherwise decrement the counter.
- Access, performed using the latched values:
  - In range (adrI < DEPTH): a write stores datI into mem[adr]; a read loads mem[adr] into datO. Then ackO=1.
  - Out of range: errO=1, no write, datO holds its previous value.
  - ackO and errO are mutually exclusive and never both 1.
- DONE:
  - ackO/errO is high for exactly this one cycle.
  - The next edge clears them and returns to IDLE.
  - The request is not re-sampled at this edge, so a held stbI cannot produce a duplicate ack.
- Throughput and latency:
  - Back-to-back requests (stbI held high) are served as new transfers from IDLE.
  - Minimum period per transfer is WAIT+2 cycles.
  - Latency from the accept edge to ackO visible is WAIT+1 edges, counting the accept edge.
- datO holds its last read value through writes, errors and idle periods.
- Input changes on adrI/datI/weI after the accept edge have no effect on the current transfer.
- Read-after-write to the same address in consecutive transfers returns the newly written data.
- Latched address comparison uses the full 32 bits; there is no aliasing of upper bits.

Test Plan:
- Reset, then hold cycI=stbI=0 for 10 cycles -> ackO=errO=0, datO=0 throughout.
- WAIT=1: write adr=5, dat=0xDEADBEEF, then read adr=5 -> each ack is a single-cycle pulse exactly 2 edges after the accept edge; the read returns datO=0xDEADBEEF in the ack cycle.
- Read adr=DEPTH (256) with DEPTH=256 -> errO pulses for one cycle, ackO stays 0, datO unchanged; a following read of adr=0 returns 0 (with INIT_ZERO=1).
- Abort: raise stb for a write adr=7, dat=0x11 with WAIT=3, drop stbI after 1 cycle -> no ack/err; a later read of adr=7 returns 0.
- Hold stbI high for 3 consecutive reads (adr=1,2,3), each address changed the cycle after its ack -> exactly 3 ack pulses spaced WAIT+2 cycles apart, with no duplicates.
- Assert rst asynchronously (mid-cycle) one cycle before the expected ack of a write adr=9, dat=0x55 -> ackO stays 0 and is never issued, FSM in IDLE after release, and mem[9] reads back unchanged.
- Run under the two-master arbiter with both masters active -> every master request completes and neither master stalls indefinitely.
